wishbone_master_xactor: RTL and testbench

Converts a stream of BSV-style bus requests into Wishbone B4 pipelined master cycles. It returns one response word per acknowledged transfer. The block sits directly upstream of the Wishbone slave transactor, driving its `CYC_I/STB_I/WE_I/ADR_I/SEL_I/DAT_I` and consuming its `STALL_O/ACK_O/DAT_O`. A bounded outstanding count and an internal response queue guarantee that no `ACK` is ever dropped.

---
 rtl/wishbone_master_xactor.sv | 115 +++++++++++
 tb/tb_wishbone_master_xactor.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_master_xactor.sv
// Wishbone B4 pipelined master: queues bus requests and issues them under a credit limit.
// Each acknowledged transfer returns one response word, in order.
module wishbone_master_xactor #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned REQ_DEPTH       = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        EN_server_request_put,
  input  logic [68:0] server_request_put,
  output logic        RDY_server_request_put,
  input  logic        EN_server_response_get,
  output logic [31:0] server_response_get,
  output logic        RDY_server_response_get,
  output logic        CYC_O,
  output logic        STB_O,
  output logic        WE_O,
  output logic [31:0] ADR_O,
  output logic [3:0]  SEL_O,
  output logic [31:0] DAT_O,
  input  logic        STALL_I,
  input  logic        ACK_I,
  input  logic [31:0] DAT_I
);

  localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned RQW = $clog2(REQ_DEPTH + 1);
  localparam int unsigned RQP = (REQ_DEPTH > 1) ? $clog2(REQ_DEPTH) : 1;
  localparam int unsigned RSP = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [68:0]    req_mem_q [REQ_DEPTH];
  logic [RQP-1:0] req_rd_q, req_rd_d, req_wr_q, req_wr_d;
  logic [RQW-1:0] req_cnt_q, req_cnt_d;
  logic [31:0]    resp_mem_q [MAX_OUTSTANDING];
  logic [RSP-1:0] resp_rd_q, resp_rd_d, resp_wr_q, resp_wr_d;
  logic [CW-1:0]  outstanding_q, outstanding_d;
  logic [CW-1:0]  resp_count_q, resp_count_d;

  logic        req_empty, req_full, credit_ok;
  logic        put, get, accept, ack_ok;
  logic [68:0] head;

  assign req_empty = (req_cnt_q == '0);
  assign req_full  = (req_cnt_q == RQW'(REQ_DEPTH));
  // Credit uses registered state only, so it cannot drop while a transfer is stalled.
  assign credit_ok = ({1'b0, outstanding_q} + {1'b0, resp_count_q}) < (CW+1)'(MAX_OUTSTANDING);

  assign head   = req_empty ? '0 : req_mem_q[req_rd_q];
  assign STB_O  = !req_empty && credit_ok;
  assign CYC_O  = STB_O || (outstanding_q != '0);
  assign WE_O   = head[68];
  assign SEL_O  = head[67:64];
  assign ADR_O  = head[63:32];
  assign DAT_O  = head[31:0];

  assign put    = EN_server_request_put && !req_full;
  assign get    = EN_server_response_get && (resp_count_q != '0);
  assign accept = STB_O && !STALL_I;
  assign ack_ok = ACK_I && (outstanding_q != '0);

  assign RDY_server_request_put  = !req_full;
  assign RDY_server_response_get = (resp_count_q != '0);
  assign server_response_get     = (resp_count_q != '0) ? resp_mem_q[resp_rd_q] : '0;

  always_comb begin
    req_cnt_d     = req_cnt_q;
    outstanding_d = outstanding_q;
    resp_count_d  = resp_count_q;
    req_rd_d      = req_rd_q;
    req_wr_d      = req_wr_q;
    resp_rd_d     = resp_rd_q;
    resp_wr_d     = resp_wr_q;

    if (put && !accept)      req_cnt_d = req_cnt_q + RQW'(1);
    else if (!put && accept) req_cnt_d = req_cnt_q - RQW'(1);

    if (accept && !ack_ok)      outstanding_d = outstanding_q + CW'(1);
    else if (!accept && ack_ok) outstanding_d = outstanding_q - CW'(1);

    if (ack_ok && !get)      resp_count_d = resp_count_q + CW'(1);
    else if (!ack_ok && get) resp_count_d = resp_count_q - CW'(1);

    if (put)    req_wr_d  = (req_wr_q == RQP'(REQ_DEPTH - 1)) ? '0 : req_wr_q + RQP'(1);
    if (accept) req_rd_d  = (req_rd_q == RQP'(REQ_DEPTH - 1)) ? '0 : req_rd_q + RQP'(1);
    if (ack_ok) resp_wr_d = (resp_wr_q == RSP'(MAX_OUTSTANDING - 1)) ? '0 : resp_wr_q + RSP'(1);
    if (get)    resp_rd_d = (resp_rd_q == RSP'(MAX_OUTSTANDING - 1)) ? '0 : resp_rd_q + RSP'(1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      req_cnt_q     <= '0;
      req_rd_q      <= '0;
      req_wr_q      <= '0;
      resp_rd_q     <= '0;
      resp_wr_q     <= '0;
      outstanding_q <= '0;
      resp_count_q  <= '0;
    end else begin
      req_cnt_q     <= req_cnt_d;
      req_rd_q      <= req_rd_d;
      req_wr_q      <= req_wr_d;
      resp_rd_q     <= resp_rd_d;
      resp_wr_q     <= resp_wr_d;
      outstanding_q <= outstanding_d;
      resp_count_q  <= resp_count_d;
    end
  end

  // Storage needs no reset: every read is gated by the occupancy counters.
  always_ff @(posedge CLK) begin
    if (put)    req_mem_q[req_wr_q]   <= server_request_put;
    if (ack_ok) resp_mem_q[resp_wr_q] <= DAT_I;
  end

endmodule

// File: tb/tb_wishbone_master_xactor.sv
// Directed bench for wishbone_master_xactor with a one-cycle-latency slave model.
module tb_wishbone_master_xactor;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        en_put = 1'b0;
  logic [68:0] put_word = '0;
  logic        rdy_put;
  logic        en_get = 1'b0;
  logic [31:0] resp;
  logic        rdy_get;
  logic        cyc, stb, we;
  logic [31:0] adr, dat_o;
  logic [3:0]  sel;
  logic        stall = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] dat_i = '0;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned stb_count, ack_seq, resp_seq, puts_left, put_idx;
  logic        prev_acc = 1'b0;

  wishbone_master_xactor #(.MAX_OUTSTANDING(4), .REQ_DEPTH(2)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .EN_server_request_put(en_put), .server_request_put(put_word),
    .RDY_server_request_put(rdy_put),
    .EN_server_response_get(en_get), .server_response_get(resp),
    .RDY_server_response_get(rdy_get),
    .CYC_O(cyc), .STB_O(stb), .WE_O(we), .ADR_O(adr), .SEL_O(sel), .DAT_O(dat_o),
    .STALL_I(stall), .ACK_I(ack), .DAT_I(dat_i)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cyc"}, {31'd0, cyc}, 32'd0);
    check({tag, "_stb"}, {31'd0, stb}, 32'd0);
    check({tag, "_we"}, {31'd0, we}, 32'd0);
    check({tag, "_adr"}, adr, 32'd0);
    check({tag, "_sel"}, {28'd0, sel}, 32'd0);
    check({tag, "_dat"}, dat_o, 32'd0);
    check({tag, "_rdy_put"}, {31'd0, rdy_put}, 32'd1);
    check({tag, "_rdy_get"}, {31'd0, rdy_get}, 32'd0);
    check({tag, "_resp"}, resp, 32'd0);
  endtask

  // Slave ACKs one cycle after each acceptance; client puts reads and optionally gets.
  task automatic run_cycles(input int unsigned n, input logic do_get);
    for (int unsigned c = 0; c < n; c++) begin
      ack = prev_acc;
      dat_i = 32'hC000_0000 + ack_seq;
      if (prev_acc) ack_seq++;
      en_put = (puts_left > 0) && rdy_put;
      put_word = {1'b0, 4'hF, 32'h0000_1000 + put_idx * 4, 32'd0};
      if (en_put) begin
        puts_left--;
        put_idx++;
      end
      en_get = do_get && rdy_get;
      if (en_get) begin
        check("burst_resp", resp, 32'hC000_0000 + resp_seq);
        resp_seq++;
      end
      prev_acc = stb && !stall;
      if (prev_acc) stb_count++;
      tick();
    end
    en_put = 1'b0;
    en_get = 1'b0;
    ack = 1'b0;
  endtask

  initial begin
    #2;
    check_reset_outputs("in_reset");
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    check_reset_outputs("after_reset");
    tick();

    // Single read
    en_put = 1'b1;
    put_word = {1'b0, 4'hF, 32'h0000_0100, 32'd0};
    tick();
    en_put = 1'b0;
    check("rd_stb", {31'd0, stb}, 32'd1);
    check("rd_adr", adr, 32'h100);
    check("rd_sel", {28'd0, sel}, 32'hF);
    check("rd_we", {31'd0, we}, 32'd0);
    tick();
    check("rd_stb_one_cycle", {31'd0, stb}, 32'd0);
    check("rd_cyc_held", {31'd0, cyc}, 32'd1);
    tick();
    ack = 1'b1;
    dat_i = 32'hDEAD_BEEF;
    tick();
    ack = 1'b0;
    check("rd_rdy_get", {31'd0, rdy_get}, 32'd1);
    check("rd_data", resp, 32'hDEAD_BEEF);
    check("rd_cyc_fall", {31'd0, cyc}, 32'd0);
    en_get = 1'b1;
    tick();
    en_get = 1'b0;
    check("rd_drained", {31'd0, rdy_get}, 32'd0);

    // Stall hold
    stall = 1'b1;
    en_put = 1'b1;
    put_word = {1'b1, 4'h3, 32'h0000_0020, 32'h0000_1234};
    tick();
    en_put = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      stall = (i < 3);
      check("st_stb", {31'd0, stb}, 32'd1);
      check("st_we", {31'd0, we}, 32'd1);
      check("st_sel", {28'd0, sel}, 32'h3);
      check("st_adr", adr, 32'h20);
      check("st_dat", dat_o, 32'h1234);
      check("st_outstanding", {29'd0, dut.outstanding_q}, 32'd0);
      tick();
    end
    check("st_issued", {29'd0, dut.outstanding_q}, 32'd1);
    check("st_stb_low", {31'd0, stb}, 32'd0);
    ack = 1'b1;
    dat_i = 32'h0000_0000;
    tick();
    ack = 1'b0;
    check("st_resp_rdy", {31'd0, rdy_get}, 32'd1);
    check("st_resp", resp, 32'h0);
    en_get = 1'b1;
    tick();
    en_get = 1'b0;

    // Pipelined burst: 6 reads, no gets until credit is exhausted
    stb_count = 0; ack_seq = 0; resp_seq = 0; puts_left = 6; put_idx = 0;
    run_cycles(20, 1'b0);
    check("bu_stb_count", stb_count, 32'd4);
    check("bu_stb_blocked", {31'd0, stb}, 32'd0);
    check("bu_resp_count", {29'd0, dut.resp_count_q}, 32'd4);
    check("bu_req_full", {31'd0, rdy_put}, 32'd0);
    run_cycles(1, 1'b1);
    check("bu_credit_back", {31'd0, stb}, 32'd1);
    run_cycles(20, 1'b1);
    check("bu_resp_total", resp_seq, 32'd6);
    check("bu_stb_total", stb_count, 32'd6);
    check("bu_cyc_end", {31'd0, cyc}, 32'd0);
    check("bu_empty", {31'd0, rdy_get}, 32'd0);

    // Stray ACK while idle
    ack = 1'b1;
    dat_i = 32'h0000_0BAD;
    tick();
    ack = 1'b0;
    tick();
    check("stray_rdy_get", {31'd0, rdy_get}, 32'd0);
    check("stray_outstanding", {29'd0, dut.outstanding_q}, 32'd0);
    check("stray_cyc", {31'd0, cyc}, 32'd0);

    // Simultaneous ACK, issue and get
    en_put = 1'b1;
    put_word = {1'b0, 4'hF, 32'h0000_0A00, 32'd0};
    tick();
    put_word = {1'b0, 4'hF, 32'h0000_0B00, 32'd0};
    tick();
    put_word = {1'b0, 4'hF, 32'h0000_0C00, 32'd0};
    ack = 1'b1;
    dat_i = 32'h0000_1111;
    tick();
    en_put = 1'b0;
    check("sim_pre_out", {29'd0, dut.outstanding_q}, 32'd1);
    check("sim_pre_resp", {29'd0, dut.resp_count_q}, 32'd1);
    check("sim_pre_stb", {31'd0, stb}, 32'd1);
    check("sim_pre_head", resp, 32'h0000_1111);
    dat_i = 32'h0000_2222;
    en_get = 1'b1;
    tick();
    en_get = 1'b0;
    check("sim_out", {29'd0, dut.outstanding_q}, 32'd1);
    check("sim_resp", {29'd0, dut.resp_count_q}, 32'd1);
    check("sim_head", resp, 32'h0000_2222);
    dat_i = 32'h0000_3333;
    tick();
    ack = 1'b0;
    check("sim_last_resp", {29'd0, dut.resp_count_q}, 32'd2);
    en_get = 1'b1;
    tick();
    check("sim_last_head", resp, 32'h0000_3333);
    tick();
    en_get = 1'b0;
    check("sim_drained", {31'd0, rdy_get}, 32'd0);

    // Reset mid-burst: 2 outstanding, 1 queued
    en_put = 1'b1;
    put_word = {1'b0, 4'hF, 32'h0000_0D00, 32'd0};
    tick();
    put_word = {1'b0, 4'hF, 32'h0000_0D04, 32'd0};
    tick();
    put_word = {1'b0, 4'hF, 32'h0000_0D08, 32'd0};
    tick();
    en_put = 1'b0;
    check("mr_pre_out", {29'd0, dut.outstanding_q}, 32'd2);
    check("mr_pre_stb", {31'd0, stb}, 32'd1);
    RST_N = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge CLK);
    RST_N = 1'b1;
    tick();
    en_put = 1'b1;
    put_word = {1'b0, 4'hF, 32'h0000_0200, 32'd0};
    tick();
    en_put = 1'b0;
    check("mr_new_stb", {31'd0, stb}, 32'd1);
    check("mr_new_adr", adr, 32'h200);
    tick();
    ack = 1'b1;
    dat_i = 32'hFEED_F00D;
    tick();
    ack = 1'b0;
    check("mr_new_rdy", {31'd0, rdy_get}, 32'd1);
    check("mr_new_data", resp, 32'hFEED_F00D);
    check("mr_new_cyc", {31'd0, cyc}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
